// File: rtl/ps2_mouse_ctrl.sv
// Stream-mode PS/2 mouse sequencer: enables reporting with retries, then assembles
// 3-byte movement packets into 9-bit signed X/Y deltas, buttons and overflow flags.
module ps2_mouse_ctrl #(
   parameter logic [7:0]  CMD_EN    = 8'hF4,
   parameter logic [7:0]  ACK_BYTE  = 8'hFA,
   parameter int unsigned ACK_TO    = 2_500_000,
   parameter int unsigned BYTE_TO   = 100_000,
   parameter int unsigned RETRY_MAX = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done_tick,
   input  logic       tx_done_tick,
   output logic       wr_ps2,
   output logic [7:0] tx_data,
   output logic [8:0] xm,
   output logic [8:0] ym,
   output logic [2:0] btnm,
   output logic [1:0] ovf,
   output logic       m_done_tick,
   output logic       init_done,
   output logic       err
);

   localparam int unsigned TMAX = (ACK_TO > BYTE_TO) ? ACK_TO : BYTE_TO;
   localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TO - 1);
   localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TO - 1);
   localparam logic [3:0]    RETRY_LIM = 4'(RETRY_MAX);

   localparam logic [2:0] SEND     = 3'd0;
   localparam logic [2:0] WAIT_TX  = 3'd1;
   localparam logic [2:0] WAIT_ACK = 3'd2;
   localparam logic [2:0] PKT1     = 3'd3;
   localparam logic [2:0] PKT2     = 3'd4;
   localparam logic [2:0] PKT3     = 3'd5;
   localparam logic [2:0] DONE     = 3'd6;
   localparam logic [2:0] ERR      = 3'd7;

   logic [2:0]    state_q, state_d;
   logic [3:0]    retry_q, retry_d;
   logic [TW-1:0] timer_q, timer_d;
   // Only the header fields the outputs need are kept from byte 1.
   logic          sx_q, sx_d, sy_q, sy_d;
   logic [1:0]    hovf_q, hovf_d;
   logic [2:0]    hbtn_q, hbtn_d;
   logic [7:0]    b2_q, b2_d;
   logic          ack_ok, pkt_upd, counting;

   assign tx_data = CMD_EN;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      hovf_d  = hovf_q;
      hbtn_d  = hbtn_q;
      b2_d    = b2_q;
      ack_ok  = 1'b0;
      pkt_upd = 1'b0;
      unique case (state_q)
         SEND:    state_d = WAIT_TX;
         WAIT_TX: if (tx_done_tick) state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (rx_done_tick && rx_data == ACK_BYTE) begin
               ack_ok  = 1'b1;
               state_d = PKT1;
            end else if (rx_done_tick || timer_q == ACK_LAST) begin
               retry_d = retry_q + 4'd1;
               state_d = (retry_d == RETRY_LIM) ? ERR : SEND;
            end
         end
         PKT1: begin
            // Bit 3 of a header byte is always set; anything else is out of sync.
            if (rx_done_tick && rx_data[3]) begin
               hovf_d  = rx_data[7:6];
               sy_d    = rx_data[5];
               sx_d    = rx_data[4];
               hbtn_d  = rx_data[2:0];
               state_d = PKT2;
            end
         end
         PKT2: begin
            if (rx_done_tick) begin
               b2_d    = rx_data;
               state_d = PKT3;
            end else if (timer_q == BYTE_LAST) begin
               state_d = PKT1;
            end
         end
         PKT3: begin
            if (rx_done_tick) begin
               pkt_upd = 1'b1;
               state_d = DONE;
            end else if (timer_q == BYTE_LAST) begin
               state_d = PKT1;
            end
         end
         DONE:    state_d = PKT1;
         ERR:     state_d = ERR;
         default: state_d = SEND;
      endcase
   end

   assign counting = (state_q == WAIT_ACK) || (state_q == PKT2) || (state_q == PKT3);

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (state_d != state_q || rx_done_tick || !counting) timer_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SEND;
         retry_q     <= 4'd0;
         timer_q     <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         hovf_q      <= 2'b00;
         hbtn_q      <= 3'b000;
         b2_q        <= 8'h00;
         wr_ps2      <= 1'b0;
         xm          <= 9'd0;
         ym          <= 9'd0;
         btnm        <= 3'b000;
         ovf         <= 2'b00;
         m_done_tick <= 1'b0;
         init_done   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         hovf_q      <= hovf_d;
         hbtn_q      <= hbtn_d;
         b2_q        <= b2_d;
         wr_ps2      <= (state_q == SEND);
         m_done_tick <= pkt_upd;
         if (pkt_upd) begin
            xm   <= {sx_q, b2_q};
            ym   <= {sy_q, rx_data};
            btnm <= hbtn_q;
            ovf  <= hovf_q;
         end
         if (ack_ok) init_done <= 1'b1;
         if (state_d == ERR) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: a deadline/queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_ps2_mouse_ctrl;

   localparam int unsigned ACK_TO    = 50;
   localparam int unsigned BYTE_TO   = 20;
   localparam int unsigned RETRY_MAX = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done_tick = 1'b0;
   logic       tx_done_tick = 1'b0;
   logic       wr_ps2;
   logic [7:0] tx_data;
   logic [8:0] xm, ym;
   logic [2:0] btnm;
   logic [1:0] ovf;
   logic       m_done_tick, init_done, err;

   ps2_mouse_ctrl #(
      .CMD_EN   (8'hF4),
      .ACK_BYTE (8'hFA),
      .ACK_TO   (ACK_TO),
      .BYTE_TO  (BYTE_TO),
      .RETRY_MAX(RETRY_MAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_done_tick(rx_done_tick),
      .tx_done_tick(tx_done_tick),
      .wr_ps2      (wr_ps2),
      .tx_data     (tx_data),
      .xm          (xm),
      .ym          (ym),
      .btnm        (btnm),
      .ovf         (ovf),
      .m_done_tick (m_done_tick),
      .init_done   (init_done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: edge counter, deadlines and a byte queue.
   int         cyc, send_at, phase, ack_deadline, retries, last_edge, done_edge;
   logic [7:0] pkt[$];
   logic       exp_wr, exp_done, exp_init, exp_err;
   logic [8:0] exp_xm, exp_ym;
   logic [2:0] exp_btn;
   logic [1:0] exp_ovf;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         cyc = 0; send_at = 1; phase = 0; retries = 0; last_edge = 0; done_edge = -10;
         ack_deadline = 0; pkt.delete();
         exp_wr = 0; exp_done = 0; exp_init = 0; exp_err = 0;
         exp_xm = 0; exp_ym = 0; exp_btn = 0; exp_ovf = 0;
      end else begin
         cyc++;
         exp_wr = 0;
         exp_done = 0;
         case (phase)
            1: if (tx_done_tick) begin phase = 2; ack_deadline = cyc + ACK_TO; end
            2: begin
               if (rx_done_tick && rx_data == 8'hFA) begin
                  exp_init = 1; phase = 3;
               end else if (rx_done_tick || cyc == ack_deadline) begin
                  retries++;
                  if (retries == RETRY_MAX) begin phase = 4; exp_err = 1; end
                  else begin phase = 0; send_at = cyc + 1; end
               end
            end
            3: if (rx_done_tick && cyc != done_edge + 1) begin
               if (pkt.size() > 0 && cyc - last_edge > BYTE_TO) pkt.delete();
               if (pkt.size() > 0 || rx_data[3]) begin
                  pkt.push_back(rx_data);
                  last_edge = cyc;
                  if (pkt.size() == 3) begin
                     exp_xm  = {pkt[0][4], pkt[1]};
                     exp_ym  = {pkt[0][5], pkt[2]};
                     exp_btn = pkt[0][2:0];
                     exp_ovf = pkt[0][7:6];
                     exp_done = 1;
                     done_edge = cyc;
                     pkt.delete();
                  end
               end
            end
            default: ;
         endcase
         if (phase == 0 && cyc == send_at) begin exp_wr = 1; phase = 1; end
      end
   end

   initial forever begin
      @(negedge clk);
      if (!reset) begin
         check("wr_ps2", wr_ps2, exp_wr);
         check("m_done_tick", m_done_tick, exp_done);
         check("init_done", init_done, exp_init);
         check("err", err, exp_err);
         check("xm", xm, exp_xm);
         check("ym", ym, exp_ym);
         check("btnm", btnm, exp_btn);
         check("ovf", ovf, exp_ovf);
         check("tx_data", tx_data, 8'hF4);
         if (wr_ps2) wr_cnt++;
         if (m_done_tick) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_data = b;
      rx_done_tick = 1'b1;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic send_tx();
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_rx(a); tick(2);
      send_rx(b); tick(2);
      send_rx(c);
   endtask

   task automatic wait_wr(input int budget, output int n);
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (wr_ps2) begin n = i; break; end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_wr"}, wr_ps2, 1'b0);
      check({tag, "_xm"}, xm, 9'd0);
      check({tag, "_ym"}, ym, 9'd0);
      check({tag, "_btn"}, btnm, 3'd0);
      check({tag, "_ovf"}, ovf, 2'd0);
      check({tag, "_done"}, m_done_tick, 1'b0);
      check({tag, "_init"}, init_done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
   endtask

   int n, w0, d0;

   initial begin
      tick(3);
      check_reset_vals("rst0");
      reset = 1'b0;

      // 1: enable command, ack
      wait_wr(5, n);
      check("first_wr_latency", n, 1);
      send_tx(); tick(2);
      send_rx(8'hFA);
      check("init_after_ack", init_done, 1'b1);
      tick(2);

      // 2: header bit5 clear, so ym sign is 0
      send_pkt(8'h09, 8'h05, 8'hFB);
      check("p2_done", m_done_tick, 1'b1);
      check("p2_xm", xm, 9'h005);
      check("p2_ym", ym, 9'h0FB);
      check("p2_btn", btnm, 3'b001);
      check("p2_ovf", ovf, 2'b00);
      tick(2);
      send_pkt(8'h29, 8'h05, 8'hFB);
      check("p2b_ym", ym, 9'h1FB);
      tick(2);

      // 3: negative X, overflow flags
      send_pkt(8'h38, 8'hF0, 8'h10);
      check("p3_xm", xm, 9'h1F0);
      check("p3_ym", ym, 9'h110);
      check("p3_btn", btnm, 3'b000);
      tick(2);
      send_pkt(8'hC8, 8'h01, 8'h02);
      check("p3_ovf", ovf, 2'b11);
      check("p3o_xm", xm, 9'h001);
      tick(2);

      // 4: stray byte discarded
      d0 = done_cnt;
      send_rx(8'h00); tick(2);
      send_pkt(8'h08, 8'h01, 8'h02);
      tick(2);
      check("p4_xm", xm, 9'h001);
      check("p4_ym", ym, 9'h002);
      check("p4_strobes", done_cnt - d0, 1);

      // 5: partial packet dropped after inter-byte timeout
      d0 = done_cnt;
      send_rx(8'h08); tick(2);
      send_rx(8'h01); tick(25);
      check("p5_no_strobe", done_cnt - d0, 0);
      send_pkt(8'h08, 8'h03, 8'h04);
      tick(2);
      check("p5_xm", xm, 9'h003);
      check("p5_ym", ym, 9'h004);
      check("p5_strobes", done_cnt - d0, 1);

      // 6: NAK, two silent timeouts, error
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("rst1");
      reset = 1'b0;
      w0 = wr_cnt;
      wait_wr(5, n);
      check("r6_wr1", n, 1);
      send_tx(); tick(2);
      send_rx(8'hFE);
      wait_wr(5, n);
      check("r6_wr_after_nak", n, 1);
      send_tx();
      wait_wr(60, n);
      check("r6_wr_after_timeout", n, ACK_TO + 1);
      send_tx();
      tick(ACK_TO + 10);
      check("r6_err", err, 1'b1);
      check("r6_wr_total", wr_cnt - w0, 3);
      d0 = done_cnt;
      send_rx(8'hFA); tick(2);
      send_pkt(8'h08, 8'h01, 8'h02);
      tick(3);
      check("r6_err_sticky", err, 1'b1);
      check("r6_no_init", init_done, 1'b0);
      check("r6_no_pkt", done_cnt - d0, 0);
      check("r6_xm_held", xm, 9'h000);

      // reset in the middle of WAIT_ACK
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_wr(5, n);
      check("r7_wr1", n, 1);
      send_tx(); tick(5);
      reset = 1'b1;
      #1;
      check_reset_vals("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      wait_wr(5, n);
      check("r7_wr_restart", n, 1);
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
